// File: rtl/alu_result_stage_if.sv
// Valid/ready bus for the ALU result stage: upstream result in, flagged result out.
interface alu_result_stage_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zr;
  logic             out_ng;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_zr, out_ng
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_zr, out_ng
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage with Hack zr/ng flags and a two-entry skid buffer.
//   state | meaning
//   EMPTY | 00: nothing buffered
//   ONE   | 10: main holds the output word
//   FULL  | 11: main and skid both hold words, in_ready low
module alu_result_stage #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  alu_result_stage_if.slave io
);
  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b10;
  localparam logic [1:0] S_FULL  = 2'b11;

  logic [WIDTH-1:0] r_main_data, r_skid_data, w_main_data, w_skid_data;
  logic             r_main_zr, r_main_ng, r_main_valid;
  logic             r_skid_zr, r_skid_ng, r_skid_valid;
  logic             w_main_zr, w_main_ng, w_main_valid;
  logic             w_skid_zr, w_skid_ng, w_skid_valid;
  logic [1:0]       w_state;
  logic             w_in_ready, w_in_xfer, w_out_xfer;
  logic             w_cap_zr, w_cap_ng;

  assign w_state    = {r_main_valid, r_skid_valid};
  assign w_in_xfer  = io.in_valid && w_in_ready;
  assign w_out_xfer = r_main_valid && io.out_ready;
  // Flags are fixed at capture time and travel with the word.
  assign w_cap_zr   = ~|io.in_data;
  assign w_cap_ng   = io.in_data[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_data  <= '0;
      r_main_zr    <= 1'b0;
      r_main_ng    <= 1'b0;
      r_main_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_zr    <= 1'b0;
      r_skid_ng    <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main_data  <= w_main_data;
      r_main_zr    <= w_main_zr;
      r_main_ng    <= w_main_ng;
      r_main_valid <= w_main_valid;
      r_skid_data  <= w_skid_data;
      r_skid_zr    <= w_skid_zr;
      r_skid_ng    <= w_skid_ng;
      r_skid_valid <= w_skid_valid;
    end
  end

  always_comb begin
    w_main_data  = r_main_data;
    w_main_zr    = r_main_zr;
    w_main_ng    = r_main_ng;
    w_main_valid = r_main_valid;
    w_skid_data  = r_skid_data;
    w_skid_zr    = r_skid_zr;
    w_skid_ng    = r_skid_ng;
    w_skid_valid = r_skid_valid;
    case (w_state)
      S_EMPTY: begin
        if (w_in_xfer) begin
          w_main_data  = io.in_data;
          w_main_zr    = w_cap_zr;
          w_main_ng    = w_cap_ng;
          w_main_valid = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_data = io.in_data;
          w_main_zr   = w_cap_zr;
          w_main_ng   = w_cap_ng;
        end else if (w_in_xfer) begin
          w_skid_data  = io.in_data;
          w_skid_zr    = w_cap_zr;
          w_skid_ng    = w_cap_ng;
          w_skid_valid = 1'b1;
        end else if (w_out_xfer) begin
          w_main_valid = 1'b0;
        end
      end
      S_FULL: begin
        if (w_out_xfer) begin
          w_main_data  = r_skid_data;
          w_main_zr    = r_skid_zr;
          w_main_ng    = r_skid_ng;
          w_skid_valid = 1'b0;
        end
      end
      default: begin
        // 01 is unreachable; recover to EMPTY if it ever appears.
        w_main_valid = 1'b0;
        w_skid_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_in_ready   = !r_skid_valid && !reset;
    io.in_ready  = w_in_ready;
    io.out_valid = r_main_valid;
    io.out_data  = r_main_data;
    io.out_zr    = r_main_zr;
    io.out_ng    = r_main_ng;
  end
endmodule
